// File: rtl/spi_pkg.sv
// Shared SPI widths, idle byte and small index helpers used by the slave-side
// schedulers.
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W  = 3;
  localparam int SPI_IDX_W  = 3;
  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;

  // Increment a requester index, wrapping to zero after n-1.
  function automatic logic [SPI_IDX_W-1:0] spi_wrap_inc(input logic [SPI_IDX_W-1:0] idx,
                                                         input int n);
    return (int'(idx) >= n - 1) ? '0 : idx + SPI_IDX_W'(1);
  endfunction
endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// scanning upward modulo NUM_REQ.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SPI_IDX_W-1:0] rr_ptr,
  output logic [SPI_IDX_W-1:0] next_grant,
  output logic                 any_req
);
  localparam int W = SPI_IDX_W + 1;

  logic [W-1:0] idx;
  logic         hit;

  // Scan from the farthest candidate down so the nearest one wins last.
  always_comb begin
    next_grant = '0;
    any_req    = 1'b0;
    idx        = '0;
    hit        = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + W'(k);
      if (idx >= W'(NUM_REQ)) idx = idx - W'(NUM_REQ);
      hit = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (idx == W'(i)) hit = req[i];
      end
      if (hit) begin
        next_grant = idx[SPI_IDX_W-1:0];
        any_req    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spi_slave_tx_arbiter.sv
// Shares one SPI slave byte channel among NUM_REQ requesters: mirrors the slave
// frame counter, grants round-robin per frame and returns each owned MOSI byte.
module spi_slave_tx_arbiter
  import spi_pkg::*;
#(
  parameter int                    NUM_REQ   = 4,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = SPI_IDLE_BYTE
) (
  input  logic                          sclk,
  input  logic                          reset,
  input  logic                          ss,
  input  logic                          mosi,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [SPI_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [SPI_BYTE_W-1:0]         tx_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            done,
  output logic [SPI_BYTE_W-1:0]         rsp_data,
  output logic                          owner_valid,
  output logic [SPI_IDX_W-1:0]          owner
);
  logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  // Only the low seven bits are kept; the completed byte is formed with mosi.
  logic [SPI_BYTE_W-2:0] shift_q, shift_d;
  logic [SPI_IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic                  owner_valid_q, owner_valid_d;
  logic [SPI_IDX_W-1:0]  owner_q, owner_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [SPI_BYTE_W-1:0] rsp_data_q, rsp_data_d;

  logic [SPI_IDX_W-1:0]  next_grant;
  logic                  any_req;
  logic                  frame_end;
  logic [SPI_BYTE_W-1:0] grant_byte;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .next_grant (next_grant),
    .any_req    (any_req)
  );

  assign frame_end = !ss && (bit_cnt_q == SPI_CNT_W'(7));

  always_comb begin
    grant_byte = IDLE_BYTE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (next_grant == SPI_IDX_W'(i)) grant_byte = req_data[SPI_BYTE_W*i +: SPI_BYTE_W];
    end
  end

  // The slave loads data_in on the frame_end edge, so this stays unregistered.
  assign tx_data = (reset || !any_req) ? IDLE_BYTE : grant_byte;

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rr_ptr_d      = rr_ptr_q;
    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;
    ack_d         = '0;
    done_d        = '0;
    rsp_data_d    = rsp_data_q;
    if (!ss) begin
      bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
      shift_d   = {shift_q[SPI_BYTE_W-3:0], mosi};
    end
    if (frame_end) begin
      rsp_data_d = {shift_q, mosi};
      for (int i = 0; i < NUM_REQ; i++) begin
        done_d[i] = owner_valid_q && (owner_q == SPI_IDX_W'(i));
      end
      if (any_req) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          ack_d[i] = (next_grant == SPI_IDX_W'(i));
        end
        owner_d       = next_grant;
        owner_valid_d = 1'b1;
        rr_ptr_d      = spi_wrap_inc(next_grant, NUM_REQ);
      end else begin
        owner_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rr_ptr_q      <= '0;
      owner_valid_q <= 1'b0;
      owner_q       <= '0;
      ack_q         <= '0;
      done_q        <= '0;
      rsp_data_q    <= '0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign rsp_data    = rsp_data_q;
  assign owner_valid = owner_valid_q;
  assign owner       = owner_q;
endmodule

// File: tb/tb_spi_slave_tx_arbiter.sv
// Scoreboard bench for spi_slave_tx_arbiter: stimulus queues expected ack/done
// events, a monitor pops and compares them whenever a pulse appears.
module tb_spi_slave_tx_arbiter;
  logic        sclk = 1'b0;
  logic        reset = 1'b1;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic [3:0]  req = 4'b0001;
  logic [31:0] req_data = 32'h0000_0042;
  logic [7:0]  tx_data;
  logic [3:0]  ack;
  logic [3:0]  done;
  logic [7:0]  rsp_data;
  logic        owner_valid;
  logic [2:0]  owner;

  spi_slave_tx_arbiter #(.NUM_REQ(4), .IDLE_BYTE(8'hFF)) dut (
    .sclk        (sclk),
    .reset       (reset),
    .ss          (ss),
    .mosi        (mosi),
    .req         (req),
    .req_data    (req_data),
    .tx_data     (tx_data),
    .ack         (ack),
    .done        (done),
    .rsp_data    (rsp_data),
    .owner_valid (owner_valid),
    .owner       (owner)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] done;
    logic [7:0] rsp;
  } ev_t;

  ev_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic expect_ev(input logic [3:0] a, input logic [3:0] d, input logic [7:0] r);
    ev_t e;
    e.ack  = a;
    e.done = d;
    e.rsp  = r;
    sb.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  initial begin
    ev_t e;
    forever begin
      @(posedge sclk);
      #1;
      if (ack != 4'b0 || done != 4'b0) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got ack=%b done=%b, required none", ack, done);
        end else begin
          e = sb.pop_front();
          chk("pulse{ack,done,rsp}",
              {16'h0, ack, done, (done != 4'b0) ? rsp_data : 8'h00},
              {16'h0, e.ack, e.done, (e.done != 4'b0) ? e.rsp : 8'h00});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] b, output logic [7:0] tx_end, output bit all_idle);
    all_idle = 1'b1;
    tx_end   = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      ss   = 1'b0;
      mosi = b[i];
      #1;
      if (tx_data !== 8'hFF) all_idle = 1'b0;
      if (i == 0) tx_end = tx_data;
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic clk_bit(input logic s, input logic b);
    ss   = s;
    mosi = b;
    @(posedge sclk);
    #1;
  endtask

  task automatic do_reset;
    ss    = 1'b1;
    req   = 4'b0;
    reset = 1'b1;
    @(posedge sclk);
    #1;
    @(negedge sclk);
    reset = 1'b0;
    @(posedge sclk);
    #1;
  endtask

  logic [7:0] txe;
  bit         idle;

  // Round-robin table: req=1011 held, bytes 10/11/_/13.
  logic [7:0] t3_mosi  [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic [7:0] t3_tx    [5] = '{8'h10, 8'h11, 8'h13, 8'h10, 8'hFF};
  logic [3:0] t3_ack   [5] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0000};
  logic [3:0] t3_done  [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
  logic [2:0] t3_owner [5] = '{3'd0, 3'd1, 3'd3, 3'd0, 3'd0};

  logic [7:0] c3 = 8'hC3;

  initial begin
    // Reset state, with a live request that must not reach tx_data.
    #2;
    chk("reset_tx_data", {24'h0, tx_data}, 32'hFF);
    chk("reset_owner_valid", {31'h0, owner_valid}, 32'h0);
    chk("reset_owner", {29'h0, owner}, 32'h0);
    chk("reset_ack_done", {24'h0, ack, done}, 32'h0);
    chk("reset_rsp_data", {24'h0, rsp_data}, 32'h0);
    req = 4'b0;
    @(negedge sclk);
    reset = 1'b0;
    @(posedge sclk);
    #1;

    // Unowned frame.
    send_frame(8'hA5, txe, idle);
    chk("idle_tx_all_ff", {31'h0, idle}, 32'h1);
    chk("idle_rsp_data", {24'h0, rsp_data}, 32'hA5);
    chk("idle_owner_valid", {31'h0, owner_valid}, 32'h0);

    // Single requester, response one frame after ack.
    req = 4'b0010;
    req_data[15:8] = 8'h3C;
    expect_ev(4'b0010, 4'b0000, 8'h00);
    send_frame(8'h00, txe, idle);
    chk("t2_tx_at_load", {24'h0, txe}, 32'h3C);
    req = 4'b0;
    chk("t2_owner", {28'h0, owner_valid, owner}, {28'h0, 1'b1, 3'd1});
    expect_ev(4'b0000, 4'b0010, 8'h5A);
    send_frame(8'h5A, txe, idle);
    chk("t2_rsp_data", {24'h0, rsp_data}, 32'h5A);
    chk("t2_owner_valid_after", {31'h0, owner_valid}, 32'h0);

    // Round robin over 1011.
    do_reset();
    req_data = 32'h1300_1110;
    req = 4'b1011;
    for (int f = 0; f < 5; f++) begin
      if (f == 4) req = 4'b0;
      expect_ev(t3_ack[f], t3_done[f], t3_mosi[f]);
      send_frame(t3_mosi[f], txe, idle);
      chk($sformatf("t3_tx_f%0d", f), {24'h0, txe}, {24'h0, t3_tx[f]});
      chk($sformatf("t3_owner_f%0d", f), {28'h0, owner_valid, owner},
          {28'h0, (f < 4), t3_owner[f]});
    end

    // Frame split by ss: frame_end only on the 8th ss-low edge.
    do_reset();
    req_data[7:0] = 8'h99;
    req = 4'b0001;
    expect_ev(4'b0001, 4'b0000, 8'h00);
    for (int i = 7; i >= 4; i--) clk_bit(1'b0, c3[i]);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, 1'b1);
    for (int i = 3; i >= 1; i--) clk_bit(1'b0, c3[i]);
    chk("split_no_early_end", {20'h0, ack, rsp_data}, 32'h0);
    chk("split_tx_before_end", {24'h0, tx_data}, 32'h99);
    clk_bit(1'b0, c3[0]);
    chk("split_end_ack", {28'h0, ack}, 32'h1);
    chk("split_rsp_data", {24'h0, rsp_data}, 32'hC3);
    req = 4'b0;

    // Back-to-back grants to the same requester.
    do_reset();
    req_data[23:16] = 8'h77;
    req = 4'b0100;
    expect_ev(4'b0100, 4'b0000, 8'h00);
    send_frame(8'h11, txe, idle);
    chk("b2b_tx_f1", {24'h0, txe}, 32'h77);
    expect_ev(4'b0100, 4'b0100, 8'h22);
    send_frame(8'h22, txe, idle);
    chk("b2b_f2_ack_done", {24'h0, ack, done}, 32'h44);
    expect_ev(4'b0100, 4'b0100, 8'h33);
    send_frame(8'h33, txe, idle);
    chk("b2b_f3_ack_done", {24'h0, ack, done}, 32'h44);
    req = 4'b0;
    expect_ev(4'b0000, 4'b0100, 8'h44);
    send_frame(8'h44, txe, idle);
    chk("b2b_tx_f4_idle", {24'h0, txe}, 32'hFF);

    // Reset in the middle of an owned frame discards it.
    do_reset();
    req_data[15:8] = 8'hE7;
    req = 4'b0010;
    expect_ev(4'b0010, 4'b0000, 8'h00);
    send_frame(8'hAA, txe, idle);
    chk("mid_tx_load", {24'h0, txe}, 32'hE7);
    req = 4'b0;
    chk("mid_owned", {31'h0, owner_valid}, 32'h1);
    for (int i = 0; i < 5; i++) clk_bit(1'b0, 1'b1);
    req_data[23:8] = 16'hA2A1;
    req = 4'b0110;
    ss = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_reset_tx", {24'h0, tx_data}, 32'hFF);
    chk("mid_reset_done", {28'h0, done}, 32'h0);
    @(negedge sclk);
    reset = 1'b0;
    @(posedge sclk);
    #1;
    chk("mid_after_owner_valid", {31'h0, owner_valid}, 32'h0);
    chk("mid_after_rr_ptr0_tx", {24'h0, tx_data}, 32'hA1);
    expect_ev(4'b0010, 4'b0000, 8'h00);
    send_frame(8'h00, txe, idle);
    req = 4'b0;
    ss = 1'b1;

    repeat (2) begin
      @(posedge sclk);
      #1;
    end
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
